// File: rtl/bus_arbiter.sv
// Two-master, three-slave bus arbiter with serial 2-bit slave address capture.
// Define ARBITER_ROUND_ROBIN_EN to alternate owners on simultaneous requests.
module bus_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_slave_select,
  input  logic       m2_slave_select,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       busy,
  output logic [1:0] bus_grant,
  output logic [1:0] slave_grant
);

  typedef enum logic [1:0] {IDLE, ADDR_MSB, ADDR_LSB, ACTIVE} state_t;

  state_t     state_reg, state_next;
  logic       m1_grant_next, m2_grant_next, busy_next;
  logic [1:0] bus_grant_next, slave_grant_next;
  logic       owner_request, owner_select;
  logic       pick_m2;

  // The grant flops double as the owner record once the bus is taken.
  assign owner_request = m1_grant ? m1_request : m2_request;
  assign owner_select  = m1_grant ? m1_slave_select : m2_slave_select;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_owner_reg;  // 1 = m2 was granted most recently

  assign pick_m2 = (m1_request && m2_request) ? !last_owner_reg : m2_request;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_reg <= 1'b1;
    end else if (state_reg == IDLE && (m1_request || m2_request)) begin
      last_owner_reg <= pick_m2;
    end
  end
`else
  assign pick_m2 = !m1_request;
`endif

  always_comb begin
    state_next       = IDLE;
    m1_grant_next    = 1'b0;
    m2_grant_next    = 1'b0;
    busy_next        = 1'b0;
    slave_grant_next = 2'b00;
    case (state_reg)
      IDLE: begin
        if (m1_request || m2_request) begin
          state_next    = ADDR_MSB;
          m1_grant_next = !pick_m2;
          m2_grant_next = pick_m2;
        end
      end
      ADDR_MSB: begin
        if (owner_request) begin
          state_next       = ADDR_LSB;
          m1_grant_next    = m1_grant;
          m2_grant_next    = m2_grant;
          slave_grant_next = {owner_select, 1'b0};
        end
      end
      ADDR_LSB: begin
        if (owner_request) begin
          state_next       = ACTIVE;
          m1_grant_next    = m1_grant;
          m2_grant_next    = m2_grant;
          busy_next        = 1'b1;
          slave_grant_next = {slave_grant[1], owner_select};
        end
      end
      ACTIVE: begin
        if (owner_request) begin
          state_next       = ACTIVE;
          m1_grant_next    = m1_grant;
          m2_grant_next    = m2_grant;
          busy_next        = 1'b1;
          slave_grant_next = slave_grant;
        end
      end
      default: state_next = IDLE;
    endcase
    bus_grant_next = {m2_grant_next, m1_grant_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      busy        <= 1'b0;
      bus_grant   <= 2'b00;
      slave_grant <= 2'b00;
    end else begin
      state_reg   <= state_next;
      m1_grant    <= m1_grant_next;
      m2_grant    <= m2_grant_next;
      busy        <= busy_next;
      bus_grant   <= bus_grant_next;
      slave_grant <= slave_grant_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter against a transaction-level owner/address model.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset, m1_request, m2_request, m1_slave_select, m2_slave_select;
  logic       m1_grant, m2_grant, busy;
  logic [1:0] bus_grant, slave_grant;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how many address bits captured, address.
  int       mdl_owner = 0;
  int       mdl_bits  = 0;
  bit [1:0] mdl_addr  = 2'b00;
  int       mdl_last  = 2;

  always #5 clk = ~clk;

  bus_arbiter arbiter (
    .clk             (clk),
    .reset           (reset),
    .m1_request      (m1_request),
    .m2_request      (m2_request),
    .m1_slave_select (m1_slave_select),
    .m2_slave_select (m2_slave_select),
    .m1_grant        (m1_grant),
    .m2_grant        (m2_grant),
    .busy            (busy),
    .bus_grant       (bus_grant),
    .slave_grant     (slave_grant)
  );

  task automatic check_value(input string tag, input logic [1:0] observed,
                             input logic [1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit r1, input bit r2,
                            input bit s1, input bit s2);
    bit req, sel;
    if (rst) begin
      mdl_owner = 0; mdl_bits = 0; mdl_addr = 2'b00; mdl_last = 2;
    end else if (mdl_owner == 0) begin
      if (r1 || r2) begin
        if (r1 && r2) begin
`ifdef ARBITER_ROUND_ROBIN_EN
          mdl_owner = (mdl_last == 1) ? 2 : 1;
`else
          mdl_owner = 1;
`endif
        end else begin
          mdl_owner = r1 ? 1 : 2;
        end
        mdl_last = mdl_owner;
        mdl_bits = 0;
        mdl_addr = 2'b00;
      end
    end else begin
      req = (mdl_owner == 1) ? r1 : r2;
      sel = (mdl_owner == 1) ? s1 : s2;
      if (!req) begin
        mdl_owner = 0; mdl_bits = 0; mdl_addr = 2'b00;
      end else if (mdl_bits < 2) begin
        mdl_addr[1 - mdl_bits] = sel;
        mdl_bits++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit r1, input bit r2,
                      input bit s1, input bit s2);
    reset = rst; m1_request = r1; m2_request = r2;
    m1_slave_select = s1; m2_slave_select = s2;
    @(posedge clk);
    #1;
    model_edge(rst, r1, r2, s1, s2);
    check_value("m1_grant", {1'b0, m1_grant}, {1'b0, mdl_owner == 1});
    check_value("m2_grant", {1'b0, m2_grant}, {1'b0, mdl_owner == 2});
    check_value("busy", {1'b0, busy}, {1'b0, mdl_bits == 2});
    check_value("bus_grant", bus_grant, 2'(mdl_owner));
    check_value("slave_grant", slave_grant, mdl_addr);
    $display("cyc rst=%0b req=%0b%0b sel=%0b%0b -> grant=%0b%0b bus=%b busy=%0b slave=%b",
             rst, r1, r2, s1, s2, m1_grant, m2_grant, bus_grant, busy, slave_grant);
  endtask

  initial begin
    bit r1, r2;
    reset = 1'b1; m1_request = 0; m2_request = 0; m1_slave_select = 0; m2_slave_select = 0;

    // Reset with random inputs
    repeat (2) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    step(0, 0, 0, 0, 0);

    // Single master m1, address 01, then release
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Contention: m1 wins, m2 select toggles, m1 releases, m2 takes over
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // m2 only, address 10
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Abort during address LSB
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Address 11 then reset while ACTIVE
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    // Both requesting, each owner releasing after ACTIVE
    repeat (3) begin
      step(0, 1, 1, 1, 1);
      step(0, 1, 1, 0, 1);
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 1);
      step(0, m2_grant, m1_grant, 0, 0);
    end
    step(0, 0, 0, 0, 0);

    // Randomized traffic with held requests and rare resets
    r1 = 0; r2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      if ($urandom_range(0, 5) == 0) r2 = ~r2;
      step($urandom_range(0, 63) == 0, r1, r2, 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
